crc_stream_checker: RTL and testbench

- Parametrised, self-sequencing CRC codeword checker. Successor to the fixed 12-bit/CRC-4 decoder.
- Accepts a codeword of DATA_W data bits and CRC_W check bits over a valid/ready handshake, and divides it serially, BITS_PER_CYCLE bits per clock.
- Presents the data, an error flag and the syndrome over a valid/ready output handshake, and keeps a saturating error counter.
- Sits between the memory read port and the consumer in the protection-code datapath; it replaces external load/shift/complete sequencing with an internal FSM.

---
 rtl/crc_stream_checker.sv | 158 +++++++++++++++
 tb/tb_crc_stream_checker.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_stream_checker.sv
// crc_stream_checker: serial CRC codeword checker with valid/ready handshakes.
// A codeword {data, crc} is taken in IDLE. It is divided MSB-first,
// BITS_PER_CYCLE bits per clock, in SHIFT. In DONE the data, the error flag
// and the syndrome are held until the consumer accepts them.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_valid, in_ready, encoded_data input handshake and codeword
//   out_valid, out_ready             output handshake
//   decoded_data, error_detected,    result of the last completed word
//   syndrome
//   busy                             FSM not in IDLE
//   err_count, clear_count           saturating errored-result counter and its clear
module crc_stream_checker #(
  parameter int unsigned          DATA_W         = 8,
  parameter int unsigned          CRC_W          = 4,
  parameter logic [CRC_W-1:0]     POLY           = CRC_W'(4'h3),
  parameter int unsigned          BITS_PER_CYCLE = 1,
  parameter int unsigned          ERR_CNT_W      = 8,
  localparam int unsigned         CODE_W         = DATA_W + CRC_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CODE_W-1:0]    encoded_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    decoded_data,
  output logic                 error_detected,
  output logic [CRC_W-1:0]     syndrome,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 clear_count
);

  localparam int unsigned NBEATS = CODE_W / BITS_PER_CYCLE;
  localparam int unsigned BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  // Reject parameter sets the datapath cannot handle.
  if ((CODE_W % BITS_PER_CYCLE) != 0) begin : g_bpc_chk
    $error("crc_stream_checker: BITS_PER_CYCLE must divide DATA_W+CRC_W");
  end
  if (POLY[0] != 1'b1) begin : g_poly_chk
    $error("crc_stream_checker: POLY bit 0 must be 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CODE_W-1:0]      shift_q, shift_d;
  logic [DATA_W-1:0]      data_q,  data_d;
  logic [CRC_W-1:0]       lfsr_q,  lfsr_d;
  logic [BEAT_W-1:0]      beat_q,  beat_d;
  logic [DATA_W-1:0]      dout_q,  dout_d;
  logic [CRC_W-1:0]       syn_q,   syn_d;
  logic                   err_q,   err_d;
  logic [ERR_CNT_W-1:0]   cnt_q,   cnt_d;

  logic [CRC_W-1:0]       lfsr_nx;
  logic                   fb;

  // One beat of division: BITS_PER_CYCLE sequential LFSR steps, MSB first.
  always_comb begin
    lfsr_nx = lfsr_q;
    fb      = 1'b0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      fb      = lfsr_nx[CRC_W-1] ^ shift_q[CODE_W-1-i];
      lfsr_nx = (lfsr_nx << 1) ^ (fb ? POLY : '0);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    data_d  = data_q;
    lfsr_d  = lfsr_q;
    beat_d  = beat_q;
    dout_d  = dout_q;
    syn_d   = syn_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d = encoded_data;
          data_d  = encoded_data[CODE_W-1:CRC_W];
          lfsr_d  = '0;
          beat_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        lfsr_d  = lfsr_nx;
        shift_d = shift_q << BITS_PER_CYCLE;
        beat_d  = beat_q + BEAT_W'(1);
        if (beat_q == BEAT_W'(NBEATS - 1)) begin
          // Result registers only change here, so they hold between words.
          dout_d  = data_q;
          syn_d   = lfsr_nx;
          err_d   = |lfsr_nx;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          if (err_q && !(&cnt_q)) begin
            cnt_d = cnt_q + ERR_CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Clear overrides a coincident increment.
    if (clear_count) begin
      cnt_d = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      data_q  <= '0;
      lfsr_q  <= '0;
      beat_q  <= '0;
      dout_q  <= '0;
      syn_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      lfsr_q  <= lfsr_d;
      beat_q  <= beat_d;
      dout_q  <= dout_d;
      syn_q   <= syn_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready       = (state_q == IDLE);
  assign out_valid      = (state_q == DONE);
  assign busy           = (state_q != IDLE);
  assign decoded_data   = dout_q;
  assign syndrome       = syn_q;
  assign error_detected = err_q;
  assign err_count      = cnt_q;

endmodule

// File: tb/tb_crc_stream_checker.sv
// Bench for crc_stream_checker: four instances (1, 2 and 4 bits per cycle,
// plus a 2-bit error counter) share one set of inputs.
module tb_crc_stream_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [11:0] enc = 12'h000;
  logic        out_ready = 1'b1;
  logic        clear = 1'b0;

  logic       ir1, ov1, bz1, ed1;
  logic [7:0] dd1, ec1;
  logic [3:0] sy1;
  logic       ir2, ov2, bz2, ed2;
  logic [7:0] dd2, ec2;
  logic [3:0] sy2;
  logic       ir4, ov4, bz4, ed4;
  logic [7:0] dd4, ec4;
  logic [3:0] sy4;
  logic       ire, ove, bze, ede;
  logic [7:0] dde;
  logic [3:0] sye;
  logic [1:0] ece;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [7:0] d;
    logic [3:0] s;
    logic       e;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  crc_stream_checker u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .encoded_data(enc),
    .out_valid(ov1), .out_ready(out_ready), .decoded_data(dd1), .error_detected(ed1),
    .syndrome(sy1), .busy(bz1), .err_count(ec1), .clear_count(clear));

  crc_stream_checker #(.BITS_PER_CYCLE(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .encoded_data(enc),
    .out_valid(ov2), .out_ready(out_ready), .decoded_data(dd2), .error_detected(ed2),
    .syndrome(sy2), .busy(bz2), .err_count(ec2), .clear_count(clear));

  crc_stream_checker #(.BITS_PER_CYCLE(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4), .encoded_data(enc),
    .out_valid(ov4), .out_ready(out_ready), .decoded_data(dd4), .error_detected(ed4),
    .syndrome(sy4), .busy(bz4), .err_count(ec4), .clear_count(clear));

  crc_stream_checker #(.ERR_CNT_W(2)) ue (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ire), .encoded_data(enc),
    .out_valid(ove), .out_ready(out_ready), .decoded_data(dde), .error_detected(ede),
    .syndrome(sye), .busy(bze), .err_count(ece), .clear_count(clear));

  // Reference remainder: long division of codeword*x^4 by x^4+x+1.
  function automatic logic [3:0] ref_syn(input logic [11:0] cw);
    logic [15:0] r;
    r = {cw, 4'b0000};
    for (int i = 15; i >= 4; i--) begin
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word for a single accept edge; optionally record its expected result.
  task automatic drive_word(input logic [11:0] w, input bit push);
    exp_t x;
    in_valid = 1'b1;
    enc      = w;
    if (push) begin
      x.d = w[11:4];
      x.s = ref_syn(w);
      x.e = (ref_syn(w) != 4'h0);
      sb.push_back(x);
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for u1 to present a result; lat counts edges since accept.
  task automatic wait_valid(output int lat, output bit to);
    lat = 0;
    while (!ov1 && lat < 40) begin
      tick();
      lat++;
    end
    to = !ov1;
  endtask

  // Pop the scoreboard head and compare it with u1's presented result.
  task automatic pop_compare(input string tag);
    exp_t x;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s: result with empty scoreboard, got data=%h syn=%h", tag, dd1, sy1);
    end else begin
      x = sb.pop_front();
      if ({dd1, sy1, ed1} !== {x.d, x.s, x.e}) begin
        failures++;
        $display("FAIL %s: got data=%h syn=%h err=%b, expected data=%h syn=%h err=%b",
                 tag, dd1, sy1, ed1, x.d, x.s, x.e);
      end
      if (x.e) exp_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clear = 1'b0;
    tick();
    tick();
    checks++;
    if ({ir1, ov1, bz1} !== 3'b100) begin
      failures++; $display("FAIL reset_hs: got ir/ov/busy=%b%b%b, expected 100", ir1, ov1, bz1);
    end
    checks++;
    if ({dd1, sy1, ed1} !== 13'h0) begin
      failures++; $display("FAIL reset_out: got data=%h syn=%h err=%b, expected zeros", dd1, sy1, ed1);
    end
    checks++;
    if (ec1 !== 8'h00) begin
      failures++; $display("FAIL reset_cnt: got %0d, expected 0", ec1);
    end
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_basic();
    int lat; bit to;
    out_ready = 1'b1;
    drive_word(12'hA5B, 1'b1);
    wait_valid(lat, to);
    checks++;
    if (to || lat != 12) begin
      failures++; $display("FAIL basic_latency: got %0d (timeout=%0b), expected 12", lat, to);
    end
    pop_compare("basic_result");
    tick();
    checks++;
    if ({ec1, ov1, ir1} !== {8'(exp_cnt), 1'b0, 1'b1}) begin
      failures++; $display("FAIL basic_after: got cnt=%0d ov=%b ir=%b, expected cnt=%0d ov=0 ir=1",
                           ec1, ov1, ir1, exp_cnt);
    end
  endtask

  task automatic test_error();
    int lat; bit to;
    drive_word(12'hA5A, 1'b1);
    wait_valid(lat, to);
    pop_compare("err_lsb_result");
    checks++;
    if (sy1 !== 4'h3) begin
      failures++; $display("FAIL err_lsb_syn: got %h, expected 3", sy1);
    end
    tick();
    checks++;
    if (ec1 !== 8'(exp_cnt)) begin
      failures++; $display("FAIL err_lsb_cnt: got %0d, expected %0d", ec1, exp_cnt);
    end
    drive_word(12'h25B, 1'b1);
    wait_valid(lat, to);
    pop_compare("err_msb_result");
    checks++;
    if (ed1 !== 1'b1 || sy1 == 4'h0) begin
      failures++; $display("FAIL err_msb_flag: got err=%b syn=%h, expected err=1 syn!=0", ed1, sy1);
    end
    tick();
    checks++;
    if (ec1 !== 8'(exp_cnt)) begin
      failures++; $display("FAIL err_msb_cnt: got %0d, expected %0d", ec1, exp_cnt);
    end
  endtask

  task automatic test_bpc();
    int lat2, lat4;
    logic [3:0] s2, s4;
    logic [7:0] d2, d4;
    test_reset();
    lat2 = 0; lat4 = 0; s2 = 4'hx; s4 = 4'hx; d2 = 8'hx; d4 = 8'hx;
    drive_word(12'hA5B, 1'b0);
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (ov2 && lat2 == 0) begin lat2 = c; s2 = sy2; d2 = dd2; end
      if (ov4 && lat4 == 0) begin lat4 = c; s4 = sy4; d4 = dd4; end
    end
    checks++;
    if (lat2 != 6 || s2 !== ref_syn(12'hA5B) || d2 !== 8'hA5) begin
      failures++; $display("FAIL bpc2: got lat=%0d syn=%h data=%h, expected lat=6 syn=%h data=a5",
                           lat2, s2, d2, ref_syn(12'hA5B));
    end
    checks++;
    if (lat4 != 3 || s4 !== ref_syn(12'hA5B) || d4 !== 8'hA5) begin
      failures++; $display("FAIL bpc4: got lat=%0d syn=%h data=%h, expected lat=3 syn=%h data=a5",
                           lat4, s4, d4, ref_syn(12'hA5B));
    end
    checks++;
    if ({ir2, ov2, bz2, ed2, ir4, ov4, bz4, ed4} !== 8'b1000_1000 || ec2 !== 8'h0 || ec4 !== 8'h0) begin
      failures++; $display("FAIL bpc_idle: got ir/ov/bz/err=%b%b%b%b %b%b%b%b cnt=%0d/%0d, expected 1000 1000 0/0",
                           ir2, ov2, bz2, ed2, ir4, ov4, bz4, ed4, ec2, ec4);
    end
  endtask

  task automatic test_backpressure();
    int lat; bit to;
    logic [7:0] hd; logic [3:0] hs; logic he;
    out_ready = 1'b0;
    drive_word(12'hA5A, 1'b1);
    wait_valid(lat, to);
    hd = dd1; hs = sy1; he = ed1;
    pop_compare("bp_result");
    for (int c = 0; c < 20; c++) begin
      in_valid = (c >= 5 && c < 9);
      enc      = 12'h123;
      tick();
      checks++;
      if ({ov1, dd1, sy1, ed1, ir1, bz1} !== {1'b1, hd, hs, he, 1'b0, 1'b1}) begin
        failures++; $display("FAIL bp_hold[%0d]: got ov=%b data=%h syn=%h err=%b ir=%b busy=%b, expected 1 %h %h %b 0 1",
                             c, ov1, dd1, sy1, ed1, ir1, bz1, hd, hs, he);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if ({bz1, ir1, ov1} !== 3'b010 || ec1 !== 8'(exp_cnt)) begin
      failures++; $display("FAIL bp_release: got busy/ir/ov=%b%b%b cnt=%0d, expected 010 cnt=%0d",
                           bz1, ir1, ov1, ec1, exp_cnt);
    end
    drive_word(12'hA5B, 1'b1);
    wait_valid(lat, to);
    checks++;
    if (to || lat != 12) begin
      failures++; $display("FAIL bp_next_latency: got %0d (timeout=%0b), expected 12", lat, to);
    end
    pop_compare("bp_next_result");
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    out_ready = 1'b1;
    drive_word(12'hA5A, 1'b0);
    for (int c = 0; c < 5; c++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({ir1, ov1, bz1} !== 3'b100 || ec1 !== 8'h00) begin
      failures++; $display("FAIL midreset: got ir/ov/busy=%b%b%b cnt=%0d, expected 100 cnt=0",
                           ir1, ov1, bz1, ec1);
    end
    rst = 1'b0;
    exp_cnt = 0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ov1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL midreset_noout: got %0d valid cycles, expected 0", seen);
    end
  endtask

  task automatic test_errcnt_sat();
    int lat; bit to; int exp_e;
    test_reset();
    out_ready = 1'b1;
    exp_e = 0;
    for (int i = 0; i < 5; i++) begin
      drive_word(12'hA5A, 1'b0);
      wait_valid(lat, to);
      checks++;
      if ({ove, dde, sye, ede} !== {1'b1, 8'hA5, ref_syn(12'hA5A), 1'b1}) begin
        failures++; $display("FAIL sat_result[%0d]: got ov=%b data=%h syn=%h err=%b, expected 1 a5 %h 1",
                             i, ove, dde, sye, ede, ref_syn(12'hA5A));
      end
      tick();
      exp_e = (exp_e < 3) ? exp_e + 1 : 3;
      checks++;
      if ({ece, ire, bze} !== {2'(exp_e), 1'b1, 1'b0}) begin
        failures++; $display("FAIL sat_cnt[%0d]: got cnt=%0d ir=%b busy=%b, expected cnt=%0d ir=1 busy=0",
                             i, ece, ire, bze, exp_e);
      end
    end
    drive_word(12'hA5A, 1'b0);
    wait_valid(lat, to);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (ece !== 2'd0 || ec1 !== 8'd0) begin
      failures++; $display("FAIL clear_wins: got cnt=%0d/%0d, expected 0/0", ece, ec1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_error();
    test_bpc();
    test_backpressure();
    test_reset_mid();
    test_errcnt_sat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
